// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: segment bit positions
// and active-high lit patterns ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] PAT_0    = 7'h3F;
    localparam logic [6:0] PAT_1    = 7'h06;
    localparam logic [6:0] PAT_2    = 7'h5B;
    localparam logic [6:0] PAT_3    = 7'h4F;
    localparam logic [6:0] PAT_4    = 7'h66;
    localparam logic [6:0] PAT_5    = 7'h6D;
    localparam logic [6:0] PAT_6    = 7'h7D;
    localparam logic [6:0] PAT_7    = 7'h07;
    localparam logic [6:0] PAT_8    = 7'h7F;
    localparam logic [6:0] PAT_9    = 7'h6F;
    localparam logic [6:0] PAT_DASH = 7'h40;

    // Active-high: every segment and the decimal point dark.
    localparam logic [7:0] BLANK_PATTERN = 8'h00;

endpackage

// File: rtl/seg7_lut.sv
// Combinational BCD digit to active-high segment pattern; non-decimal codes
// map to a dash and raise the invalid flag.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg,
    output logic       invalid
);

    always_comb begin
        seg     = PAT_DASH;
        invalid = 1'b0;
        case (digit)
            4'd0:    seg = PAT_0;
            4'd1:    seg = PAT_1;
            4'd2:    seg = PAT_2;
            4'd3:    seg = PAT_3;
            4'd4:    seg = PAT_4;
            4'd5:    seg = PAT_5;
            4'd6:    seg = PAT_6;
            4'd7:    seg = PAT_7;
            4'd8:    seg = PAT_8;
            4'd9:    seg = PAT_9;
            default: begin
                seg     = PAT_DASH;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bcd_to_seven_seg_decoder.sv
// Registered single-digit seven-segment driver with decimal point, blanking
// and build-time output polarity.
module bcd_to_seven_seg_decoder
    import seg7_pkg::*;
#(
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] out,
    output logic       invalid
);

    localparam logic [7:0] OFF_PATTERN = BLANK_PATTERN ^ {8{ACTIVE_LOW}};

    logic [6:0] lut_seg;
    logic       lut_invalid;
    logic [7:0] out_d, out_q;
    logic       invalid_d, invalid_q;
    logic [7:0] pat_hi;

    seg7_lut u_lut (
        .digit   (in),
        .seg     (lut_seg),
        .invalid (lut_invalid)
    );

    // Blank wins over digit and dp, but invalid still tracks the input code.
    always_comb begin
        pat_hi            = BLANK_PATTERN;
        pat_hi[SEG_G:SEG_A] = lut_seg;
        pat_hi[SEG_DP]    = dp;
        if (blank) begin
            pat_hi = BLANK_PATTERN;
        end
        out_d     = pat_hi ^ {8{ACTIVE_LOW}};
        invalid_d = lut_invalid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= OFF_PATTERN;
            invalid_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            invalid_q <= invalid_d;
        end
    end

    assign out     = out_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_seven_seg_decoder.sv
// Scoreboard bench: common-anode and common-cathode builds driven in parallel,
// expected responses queued at stimulus time and checked by a monitor.
module tb_bcd_to_seven_seg_decoder;

    typedef struct packed {
        logic [7:0] out_al;
        logic       inv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_s;
    logic       dp_s;
    logic       blank_s;
    logic [7:0] out1, out0;
    logic       inv1, inv0;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    bcd_to_seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .in(in_s), .dp(dp_s), .blank(blank_s),
        .out(out1), .invalid(inv1)
    );

    bcd_to_seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst_n(rst_n), .in(in_s), .dp(dp_s), .blank(blank_s),
        .out(out0), .invalid(inv0)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply(input logic [3:0] d, input logic p, input logic b,
                         input logic [7:0] e_out, input logic e_inv);
        exp_t e;
        @(negedge clk);
        in_s = d; dp_s = p; blank_s = b;
        e.out_al = e_out;
        e.inv    = e_inv;
        sbq.push_back(e);
    endtask

    // Monitor: one registered result per queued stimulus, sampled after the edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("out_al1", out1, e.out_al);
            chk("inv_al1", {7'd0, inv1}, {7'd0, e.inv});
            chk("out_al0", out0, ~e.out_al);
            chk("inv_al0", {7'd0, inv0}, {7'd0, e.inv});
        end
    end

    initial begin
        logic [7:0] dig_exp [10];
        int wait_cyc;
        dig_exp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

        rst_n = 1'b0; in_s = 4'd5; dp_s = 1'b0; blank_s = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_al1", out1, 8'hFF);
        chk("rst_out_al0", out0, 8'h00);
        chk("rst_inv", {7'd0, inv1}, 8'h00);

        // Release with inputs applied in the same cycle.
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd5, 1'b0, 1'b0, 8'h92, 1'b0);

        for (int d = 0; d < 10; d++)
            for (int k = 0; k < 10; k++)
                apply(d[3:0], 1'b0, 1'b0, dig_exp[d], 1'b0);

        for (int d = 10; d < 16; d++)
            apply(d[3:0], 1'b0, 1'b0, 8'hBF, 1'b1);
        apply(4'd3, 1'b0, 1'b0, 8'hB0, 1'b0);

        apply(4'd8, 1'b1, 1'b0, 8'h00, 1'b0);
        apply(4'd8, 1'b1, 1'b1, 8'hFF, 1'b0);
        apply(4'd12, 1'b0, 1'b1, 8'hFF, 1'b1);
        apply(4'd13, 1'b1, 1'b0, 8'h3F, 1'b1);
        apply(4'd0, 1'b0, 1'b0, 8'hC0, 1'b0);
        apply(4'd1, 1'b0, 1'b0, 8'hF9, 1'b0);
        apply(4'd7, 1'b0, 1'b0, 8'hF8, 1'b0);

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        chk("out_before_async_rst", out1, 8'hF8);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_al1", out1, 8'hFF);
        chk("async_rst_out_al0", out0, 8'h00);
        chk("async_rst_inv", {7'd0, inv1}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd11, 1'b0, 1'b0, 8'hBF, 1'b1);

        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_seven_seg_decoder.md
# bcd_to_seven_seg_decoder

Converts one 4-bit BCD digit into an 8-bit seven-segment-plus-decimal-point drive pattern, registered on the system clock. It sits between the vending-machine display logic (credit/price digits) and the board's seven-segment pins. It drives one digit; multi-digit scanning is handled outside this block.

## Interface
- ACTIVE_LOW, default 1: 1 means a lit segment is driven 0 (common-anode board); 0 inverts all eight output bits.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  4  BCD digit; 0–9 are valid, 10–15 are invalid.
- dp  input  1  1 lights the decimal point.
- blank  input  1  1 turns off all segments and the decimal point.
- out  output  8  segment drive: out[0]=a, out[1]=b, … out[6]=g, out[7]=dp.
- invalid  output  1  1 when the registered digit was outside 0–9.

## Operation
- Segment map, lit set per digit:
  - 0 = abcdef
  - 1 = bc
  - 2 = abdeg
  - 3 = abcdg
  - 4 = bcfg
  - 5 = acdfg
  - 6 = acdefg
  - 7 = abc
  - 8 = abcdefg
  - 9 = abcdfg
- With ACTIVE_LOW=1 and dp=0, out is C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex) for digits 0–9.
- Codes 10–15 display a dash (g only, out=BF with ACTIVE_LOW=1, dp=0), and invalid=1 for that cycle.
- dp=1 lights out[7] (clears bit 7 when ACTIVE_LOW=1) for any digit, including dashes.
- blank has priority over everything:
  - out = all segments off (FF when ACTIVE_LOW=1, 00 otherwise), regardless of in and dp.
  - invalid still reflects in.
- Polarity is applied last, as a single XOR of the active-high pattern with {8{ACTIVE_LOW}}.
- No internal state other than the output registers.

## Timing
- in, dp and blank are sampled at each rising edge of clk. out and invalid update after that edge, so latency is exactly 1 cycle, with no bubble and no stall.
- Inputs held constant give constant outputs; no glitches at outputs between edges.
- rst_n low, asynchronously: out = all-off pattern (FF for ACTIVE_LOW=1), invalid=0. These values hold while rst_n is low.
- First rst_n-high rising edge loads the decoded current inputs.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.
- Input change in the same cycle as reset release: decoded on the first edge with rst_n high.

## Structure
- Shared package seg7_pkg holds:
  - segment-index constants SEG_A..SEG_G, SEG_DP
  - active-high digit pattern constants for 0–9 and DASH
  - the BLANK_PATTERN constant
- Sub-module seg7_lut: purely combinational, takes 4-bit digit and returns a 7-bit active-high pattern plus an invalid flag.
- Top level adds dp/blank muxing, polarity XOR and the output registers.

## Test plan
- Reset: hold rst_n=0 with in=5 and clocks running -> out=FF, invalid=0. Release -> after 1 edge, out=92.
- Sweep in=0..9, each held 10 cycles, with dp=0, blank=0, ACTIVE_LOW=1 -> out matches C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 one cycle after each change; invalid=0 throughout.
- in=10..15 -> out=BF and invalid=1 for each. Then in=3 -> out=B0, invalid=0.
- Overrides:
  - dp=1 with in=8 -> out=00
  - blank=1 with in=8, dp=1 -> out=FF
  - blank=1 with in=12 -> out=FF, invalid=1
- ACTIVE_LOW=0 build:
  - in=0 -> out=3F; in=1 -> out=06; reset -> out=00.
- Assert rst_n low between clock edges while out=F8 -> out becomes FF before the next edge.
